// File: rtl/rf_writeback_ctrl.sv
// Register-file write-back controller: source-selected destination, DEPTH-stage pipeline, RAW scoreboard.
// rf_we lands DEPTH cycles after acceptance (+1 per wb_stall cycle); RF_FORWARD_EN adds youngest-data forwarding.
module rf_writeback_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 2,
  parameter int LINK_REG  = 13,
  parameter int ZERO_REG  = 0,
  parameter int ZERO_DROP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [1:0]             wr_sel,
  input  logic [ADDR_W-1:0]      ir_addr,
  input  logic [ADDR_W-1:0]      alt_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wb_stall,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
`ifdef RF_FORWARD_EN
  output logic [DATA_W-1:0]      fwd_data_a,
  output logic [DATA_W-1:0]      fwd_data_b,
`endif
  output logic [2**ADDR_W-1:0]   pending
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam bit DROP_EN = (ZERO_DROP != 0);

  logic [ADDR_W-1:0] sel_addr;
  logic              accept;

  logic [DEPTH-1:0]  stg_vld;
  logic [ADDR_W-1:0] stg_addr [DEPTH];
  logic [DATA_W-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0]  stg_live;

  always_comb begin
    sel_addr = ir_addr;
    case (wr_sel)
      2'b00:   sel_addr = ir_addr;
      2'b01:   sel_addr = LINK_A;
      2'b10:   sel_addr = ZERO_A;
      default: sel_addr = alt_addr;
    endcase
  end

  assign wr_ready = !wb_stall;
  assign accept   = wr_valid && wr_ready;

  // A stall freezes every stage; otherwise stage 0 takes the request or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stg_addr[k] <= '0;
        stg_data[k] <= '0;
      end
    end else if (!wb_stall) begin
      stg_vld[0] <= accept;
      if (accept) begin
        stg_addr[0] <= sel_addr;
        stg_data[0] <= wr_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        stg_vld[k]  <= stg_vld[k-1];
        stg_addr[k] <= stg_addr[k-1];
        stg_data[k] <= stg_data[k-1];
      end
    end
  end

  // A stage is live when it will really write; dropped zero-register writes never count.
  always_comb begin
    stg_live = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stg_live[k] = stg_vld[k] && !(DROP_EN && (stg_addr[k] == ZERO_A));
    end
  end

  assign rf_we    = stg_live[DEPTH-1] && !wb_stall;
  assign rf_waddr = stg_addr[DEPTH-1];
  assign rf_wdata = stg_data[DEPTH-1];

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stg_live[k]) pending[stg_addr[k]] = 1'b1;
    end
  end

`ifdef RF_FORWARD_EN
  logic fwd_hit_a;
  logic fwd_hit_b;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (stg_live[k] && (stg_addr[k] == rd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = stg_data[k];
      end
      if (stg_live[k] && (stg_addr[k] == rd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = stg_data[k];
      end
    end
  end

  assign hazard_a = pending[rd_addr_a] && !fwd_hit_a;
  assign hazard_b = pending[rd_addr_b] && !fwd_hit_b;
`else
  assign hazard_a = pending[rd_addr_a];
  assign hazard_b = pending[rd_addr_b];
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_writeback_ctrl;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 2;
  localparam int LINK_REG  = 13;
  localparam int ZERO_REG  = 0;
  localparam int ZERO_DROP = 1;
  localparam int NREG      = 2**ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] alt_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wb_stall;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0]   pending;
`ifdef RF_FORWARD_EN
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
`endif

  int errors = 0;
  int checks = 0;

  rf_writeback_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .LINK_REG(LINK_REG), .ZERO_REG(ZERO_REG), .ZERO_DROP(ZERO_DROP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .ir_addr(ir_addr), .alt_addr(alt_addr), .wr_data(wr_data),
    .wb_stall(wb_stall), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_FORWARD_EN
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
`endif
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: in-flight writes with the number of unstalled edges since acceptance.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                age;
  } ent_t;
  ent_t q[$];

  function automatic logic [ADDR_W-1:0] m_sel(input logic [1:0] s, input logic [ADDR_W-1:0] ir,
                                              input logic [ADDR_W-1:0] alt);
    case (s)
      2'd0:    return ir;
      2'd1:    return ADDR_W'(LINK_REG);
      2'd2:    return ADDR_W'(ZERO_REG);
      default: return alt;
    endcase
  endfunction

  function automatic bit m_drop(input logic [ADDR_W-1:0] a);
    return (ZERO_DROP != 0) && (a == ADDR_W'(ZERO_REG));
  endfunction

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p = '0;
    foreach (q[i]) if (!m_drop(q[i].addr)) p[q[i].addr] = 1'b1;
    return p;
  endfunction

  function automatic bit m_we();
    foreach (q[i]) if (q[i].age == DEPTH-1 && !m_drop(q[i].addr) && !wb_stall) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t m_out();
    ent_t e;
    e.addr = '0; e.data = '0; e.age = 0;
    foreach (q[i]) if (q[i].age == DEPTH-1) e = q[i];
    return e;
  endfunction

  function automatic bit m_fwd(input logic [ADDR_W-1:0] rd, output logic [DATA_W-1:0] d);
    int best = DEPTH + 1;
    d = '0;
    foreach (q[i]) begin
      if (q[i].addr == rd && !m_drop(q[i].addr) && q[i].age < best) begin
        best = q[i].age;
        d    = q[i].data;
      end
    end
    return best <= DEPTH;
  endfunction

  function automatic bit m_hazard(input logic [ADDR_W-1:0] rd);
    logic [NREG-1:0]   p = m_pending();
    logic [DATA_W-1:0] d;
    bit                h = p[rd];
`ifdef RF_FORWARD_EN
    if (m_fwd(rd, d)) h = 1'b0;
`else
    if (m_fwd(rd, d) && !h) h = 1'b0;
`endif
    return h;
  endfunction

  task automatic drive(input bit v, input logic [1:0] s, input logic [ADDR_W-1:0] ir,
                       input logic [ADDR_W-1:0] alt, input logic [DATA_W-1:0] d, input bit st);
    wr_valid = v; wr_sel = s; ir_addr = ir; alt_addr = alt; wr_data = d; wb_stall = st;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, '0, 1'b0);
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, return at the next negedge.
  task automatic tick();
    ent_t nq[$];
    ent_t e;
    @(posedge clk);
    if (rst_n && !wb_stall) begin
      foreach (q[i]) begin
        if (q[i].age < DEPTH-1) begin
          e = q[i];
          e.age++;
          nq.push_back(e);
        end
      end
      if (wr_valid) begin
        e.addr = m_sel(wr_sel, ir_addr, alt_addr);
        e.data = wr_data;
        e.age  = 0;
        nq.push_back(e);
      end
      q = nq;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_addr_a = ADDR_W'(5); rd_addr_b = ADDR_W'(5);
    drive(1'b1, 2'd3, '0, ADDR_W'(5), 16'hBEEF, 1'b0);
    q.delete();
    repeat (3) @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    checks++; if (rf_waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", rf_waddr); end
    checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", rf_wdata); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    checks++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
      errors++; $display("FAIL reset_hazard: got %b%b expected 00", hazard_a, hazard_b);
    end
    idle();
    rst_n = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
  endtask

  task automatic test_sources();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [DATA_W-1:0] exp_data [4];
    int  k;
    bit  exp_we;
    exp_addr[0] = ADDR_W'(3); exp_addr[1] = ADDR_W'(LINK_REG);
    exp_addr[2] = ADDR_W'(ZERO_REG); exp_addr[3] = ADDR_W'(7);
    exp_data[0] = 16'h1111; exp_data[1] = 16'h2222; exp_data[2] = 16'h3333; exp_data[3] = 16'h4444;
    rd_addr_a = '0; rd_addr_b = '0;
    for (int c = 0; c <= DEPTH + 5; c++) begin
      if (c < 4) drive(1'b1, 2'(c), ADDR_W'(3), ADDR_W'(7), exp_data[c], 1'b0);
      else idle();
      #1;
      k = c - DEPTH;
      exp_we = (k >= 0) && (k <= 3) && !((k == 2) && (ZERO_DROP != 0));
      checks++; if (rf_we !== exp_we) begin
        errors++; $display("FAIL src_we c=%0d: got %b expected %b", c, rf_we, exp_we);
      end
      if (exp_we) begin
        checks++; if (rf_waddr !== exp_addr[k] || rf_wdata !== exp_data[k]) begin
          errors++; $display("FAIL src_port c=%0d: got %0h/%0h expected %0h/%0h",
                             c, rf_waddr, rf_wdata, exp_addr[k], exp_data[k]);
        end
      end
      if (ZERO_DROP != 0) begin
        checks++; if (pending[ZERO_REG] !== 1'b0) begin
          errors++; $display("FAIL src_zero_pending c=%0d: got 1 expected 0", c);
        end
      end
      tick();
    end
  endtask

  task automatic test_hazard_window();
    bit exp_h;
    rd_addr_a = ADDR_W'(5); rd_addr_b = ADDR_W'(6);
    for (int c = 0; c <= DEPTH + 2; c++) begin
      if (c == 0) drive(1'b1, 2'd0, ADDR_W'(5), '0, 16'h5555, 1'b0);
      else idle();
      #1;
      exp_h = (c >= 1) && (c <= DEPTH);
`ifdef RF_FORWARD_EN
      if (exp_h) begin
        checks++; if (fwd_data_a !== 16'h5555) begin
          errors++; $display("FAIL haz_fwd c=%0d: got %0h expected 5555", c, fwd_data_a);
        end
      end
      exp_h = 1'b0;
`endif
      checks++; if (hazard_a !== exp_h) begin
        errors++; $display("FAIL haz_a c=%0d: got %b expected %b", c, hazard_a, exp_h);
      end
      checks++; if (hazard_b !== 1'b0) begin
        errors++; $display("FAIL haz_b c=%0d: got %b expected 0", c, hazard_b);
      end
      checks++; if (rf_we !== (c == DEPTH)) begin
        errors++; $display("FAIL haz_we c=%0d: got %b expected %b", c, rf_we, c == DEPTH);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int s = (DEPTH > 1) ? 2 : 1;
    bit st;
    rd_addr_a = ADDR_W'(2); rd_addr_b = '0;
    for (int c = 0; c <= DEPTH + 5; c++) begin
      st = (c >= s) && (c < s + 3);
      if (c == 0) drive(1'b1, 2'd0, ADDR_W'(2), '0, 16'h2222, 1'b0);
      else if (st) drive(1'b1, 2'd3, '0, ADDR_W'(11), 16'hDEAD, 1'b1);
      else idle();
      #1;
      checks++; if (wr_ready !== !st) begin
        errors++; $display("FAIL stall_ready c=%0d: got %b expected %b", c, wr_ready, !st);
      end
      checks++; if (rf_we !== (c == DEPTH + 3)) begin
        errors++; $display("FAIL stall_we c=%0d: got %b expected %b", c, rf_we, c == DEPTH + 3);
      end
      if (c == DEPTH + 3) begin
        checks++; if (rf_waddr !== ADDR_W'(2) || rf_wdata !== 16'h2222) begin
          errors++; $display("FAIL stall_port: got %0h/%0h expected 2/2222", rf_waddr, rf_wdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    rd_addr_a = ADDR_W'(9); rd_addr_b = '0;
    for (int c = 0; c <= DEPTH + 3; c++) begin
      if (c == 0) drive(1'b1, 2'd0, ADDR_W'(9), '0, 16'hAAAA, 1'b0);
      else if (c == 1) drive(1'b1, 2'd0, ADDR_W'(9), '0, 16'hBBBB, 1'b0);
      else idle();
      #1;
      checks++; if (rf_we !== (c == DEPTH || c == DEPTH + 1)) begin
        errors++; $display("FAIL b2b_we c=%0d: got %b", c, rf_we);
      end
      if (c == DEPTH || c == DEPTH + 1) begin
        checks++; if (rf_waddr !== ADDR_W'(9) || rf_wdata !== ((c == DEPTH) ? 16'hAAAA : 16'hBBBB)) begin
          errors++; $display("FAIL b2b_port c=%0d: got %0h/%0h expected 9/%0h", c, rf_waddr, rf_wdata,
                             (c == DEPTH) ? 16'hAAAA : 16'hBBBB);
        end
      end
      checks++; if (pending[9] !== (c >= 1 && c <= DEPTH + 1)) begin
        errors++; $display("FAIL b2b_pending c=%0d: got %b expected %b", c, pending[9], c >= 1 && c <= DEPTH + 1);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    rd_addr_a = ADDR_W'(8); rd_addr_b = ADDR_W'(6);
    drive(1'b1, 2'd0, ADDR_W'(6), '0, 16'h0606, 1'b0); tick();
    drive(1'b1, 2'd0, ADDR_W'(8), '0, 16'h0808, 1'b0); tick();
    idle();
    #1;
    checks++; if (pending[8] !== 1'b1) begin
      errors++; $display("FAIL mid_inflight: got %b expected 1", pending[8]);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || pending !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      errors++; $display("FAIL mid_clear: got we=%b pend=%0h addr=%0h data=%0h expected all 0",
                         rf_we, pending, rf_waddr, rf_wdata);
    end
    checks++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
      errors++; $display("FAIL mid_hazard: got %b%b expected 00", hazard_a, hazard_b);
    end
    #1;
    rst_n = 1'b1;
    q.delete();
    tick();
    for (int c = 0; c <= DEPTH + 2; c++) begin
      idle();
      #1;
      checks++; if (rf_we !== 1'b0 || pending !== '0) begin
        errors++; $display("FAIL mid_after c=%0d: got we=%b pend=%0h expected 0/0", c, rf_we, pending);
      end
      tick();
    end
  endtask

`ifdef RF_FORWARD_EN
  task automatic test_forward();
    rd_addr_a = ADDR_W'(4); rd_addr_b = '0;
    for (int c = 0; c <= DEPTH + 2; c++) begin
      if (c == 0) drive(1'b1, 2'd0, ADDR_W'(4), '0, 16'h5678, 1'b0);
      else if (c == DEPTH - 1) drive(1'b1, 2'd0, ADDR_W'(4), '0, 16'h1234, 1'b0);
      else idle();
      #1;
      if (c == DEPTH) begin
        checks++; if (fwd_data_a !== 16'h1234) begin
          errors++; $display("FAIL fwd_young: got %0h expected 1234", fwd_data_a);
        end
        checks++; if (hazard_a !== 1'b0) begin
          errors++; $display("FAIL fwd_hazard: got %b expected 0", hazard_a);
        end
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 16'h5678) begin
          errors++; $display("FAIL fwd_old_write: got %b/%0h expected 1/5678", rf_we, rf_wdata);
        end
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [ADDR_W-1:0] ra, rb;
    logic [DATA_W-1:0] fd;
    ent_t e;
    bit   st, ew, eh_a, eh_b, hit;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 99) < 20);
      drive($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), ADDR_W'($urandom),
            ADDR_W'($urandom), DATA_W'($urandom), st);
      ra = ADDR_W'($urandom);
      rb = ADDR_W'($urandom);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) ra = q[$urandom_range(0, q.size() - 1)].addr;
      rd_addr_a = ra; rd_addr_b = rb;
      #1;
      ew = m_we(); e = m_out(); eh_a = m_hazard(ra); eh_b = m_hazard(rb);
      checks++; if (wr_ready !== !st) begin
        errors++; $display("FAIL rnd_ready n=%0d: got %b expected %b", n, wr_ready, !st);
      end
      checks++; if (rf_we !== ew) begin
        errors++; $display("FAIL rnd_we n=%0d: got %b expected %b", n, rf_we, ew);
      end
      if (ew) begin
        checks++; if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++; $display("FAIL rnd_port n=%0d: got %0h/%0h expected %0h/%0h", n, rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
      checks++; if (pending !== m_pending()) begin
        errors++; $display("FAIL rnd_pending n=%0d: got %0h expected %0h", n, pending, m_pending());
      end
      checks++; if (hazard_a !== eh_a || hazard_b !== eh_b) begin
        errors++; $display("FAIL rnd_hazard n=%0d: got %b%b expected %b%b", n, hazard_a, hazard_b, eh_a, eh_b);
      end
`ifdef RF_FORWARD_EN
      hit = m_fwd(ra, fd);
      checks++; if (fwd_data_a !== fd) begin
        errors++; $display("FAIL rnd_fwd_a n=%0d: got %0h expected %0h", n, fwd_data_a, fd);
      end
      hit = m_fwd(rb, fd);
      checks++; if (fwd_data_b !== fd) begin
        errors++; $display("FAIL rnd_fwd_b n=%0d: got %0h expected %0h", n, fwd_data_b, fd);
      end
`else
      hit = m_fwd(ra, fd);
`endif
      tick();
    end
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    test_reset();
    test_sources();
    test_hazard_window();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
`ifdef RF_FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
